cdb_lane_arbiter: RTL and testbench

CDB_LANE_ARBITER -- requirements
Module: cdb_lane_arbiter

---
 rtl/cdb_lane_arbiter.sv | 81 ++++++++
 tb/tb_cdb_lane_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/cdb_lane_arbiter.sv
// cdb_lane_arbiter: round-robin selection of up to LANES functional-unit results per cycle
// onto registered common-data-bus lanes; lane k carries the k-th grant in scan order.
module cdb_lane_arbiter #(
  parameter int FU_NUM    = 8,
  parameter int LANES     = 2,
  parameter int WORD_SIZE = 32,
  parameter int RB_INDEX  = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic                              hold,
  input  logic [FU_NUM-1:0]                 req,
  input  logic [FU_NUM*WORD_SIZE-1:0]       data_bus,
  input  logic [FU_NUM*WORD_SIZE-1:0]       addr_bus,
  input  logic [FU_NUM*RB_INDEX-1:0]        RB_index_bus,
  output logic [FU_NUM-1:0]                 gnt,
  output logic [LANES-1:0]                  lane_valid,
  output logic [LANES*WORD_SIZE-1:0]        lane_data,
  output logic [LANES*WORD_SIZE-1:0]        lane_addr,
  output logic [LANES*RB_INDEX-1:0]         lane_RB_index,
  output logic [LANES*$clog2(FU_NUM)-1:0]   lane_src
);
  localparam int SW = $clog2(FU_NUM);
  logic [SW-1:0]              ptr_q, ptr_d, last;
  logic [LANES-1:0]           valid_q, valid_d;
  logic [LANES*WORD_SIZE-1:0] data_q, data_d, addr_q, addr_d;
  logic [LANES*RB_INDEX-1:0]  rb_q, rb_d;
  logic [LANES*SW-1:0]        src_q, src_d;
  logic                       en;
  int                         n, idx;
  // Scan from ptr and hand the k-th requester found to lane k; reset also gates grants.
  always_comb begin
    en = !(hold || flush || reset);
    gnt = '0;
    valid_d = '0;
    data_d = '0;
    addr_d = '0;
    rb_d = '0;
    src_d = '0;
    last = ptr_q;
    n = 0;
    idx = 0;
    for (int j = 0; j < FU_NUM; j++) begin
      idx = (int'(ptr_q) + j) % FU_NUM;
      if (en && req[idx] && n < LANES) begin
        gnt[idx] = 1'b1;
        valid_d[n] = 1'b1;
        data_d[n*WORD_SIZE +: WORD_SIZE] = data_bus[idx*WORD_SIZE +: WORD_SIZE];
        addr_d[n*WORD_SIZE +: WORD_SIZE] = addr_bus[idx*WORD_SIZE +: WORD_SIZE];
        rb_d[n*RB_INDEX +: RB_INDEX] = RB_index_bus[idx*RB_INDEX +: RB_INDEX];
        src_d[n*SW +: SW] = SW'(idx);
        last = SW'(idx);
        n = n + 1;
      end
    end
    ptr_d = flush ? '0 : (n > 0 ? SW'((int'(last) + 1) % FU_NUM) : ptr_q);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      valid_q <= '0;
      data_q <= '0;
      addr_q <= '0;
      rb_q <= '0;
      src_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      valid_q <= valid_d;
      data_q <= data_d;
      addr_q <= addr_d;
      rb_q <= rb_d;
      src_q <= src_d;
    end
  end
  assign lane_valid = valid_q;
  assign lane_data = data_q;
  assign lane_addr = addr_q;
  assign lane_RB_index = rb_q;
  assign lane_src = src_q;
endmodule

// File: tb/tb_cdb_lane_arbiter.sv
// tb_cdb_lane_arbiter: table-driven vectors plus async-reset and fairness sequences.
module tb_cdb_lane_arbiter;
  localparam int FU = 8, L = 2, W = 32, R = 4, S = 3;
  logic clk = 1'b0;
  logic reset, flush, hold;
  logic [FU-1:0] req, gnt;
  logic [FU*W-1:0] data_bus, addr_bus;
  logic [FU*R-1:0] rb_bus;
  logic [L-1:0] lane_valid;
  logic [L*W-1:0] lane_data, lane_addr;
  logic [L*R-1:0] lane_rb;
  logic [L*S-1:0] lane_src;
  logic [W-1:0] dv[FU], av[FU];
  logic [R-1:0] rv[FU];
  int total = 0, bad = 0;
  typedef struct {
    logic       hold;
    logic       flush;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [1:0] v;
    int         s0;
    int         s1;
  } vec_t;
  vec_t tv[17];

  cdb_lane_arbiter #(.FU_NUM(FU), .LANES(L), .WORD_SIZE(W), .RB_INDEX(R)) dut (
    .clk(clk), .reset(reset), .flush(flush), .hold(hold), .req(req),
    .data_bus(data_bus), .addr_bus(addr_bus), .RB_index_bus(rb_bus),
    .gnt(gnt), .lane_valid(lane_valid), .lane_data(lane_data),
    .lane_addr(lane_addr), .lane_RB_index(lane_rb), .lane_src(lane_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_lanes(input string tag, input logic [1:0] v, input int s0, input int s1);
    logic [L*W-1:0] ed, ea;
    logic [L*R-1:0] er;
    logic [L*S-1:0] es;
    int s[2];
    s[0] = s0;
    s[1] = s1;
    ed = '0;
    ea = '0;
    er = '0;
    es = '0;
    for (int k = 0; k < L; k++)
      if (v[k]) begin
        ed[k*W +: W] = dv[s[k]];
        ea[k*W +: W] = av[s[k]];
        er[k*R +: R] = rv[s[k]];
        es[k*S +: S] = S'(s[k]);
      end
    chk({tag, ".valid"}, 64'(lane_valid), 64'(v));
    chk({tag, ".src"}, 64'(lane_src), 64'(es));
    chk({tag, ".data"}, 64'(lane_data), 64'(ed));
    chk({tag, ".addr"}, 64'(lane_addr), 64'(ea));
    chk({tag, ".rb"}, 64'(lane_rb), 64'(er));
  endtask

  initial begin
    int gap;
    for (int i = 0; i < FU; i++) begin
      dv[i] = 32'h1000_0000 + 32'(i) * 32'h111;
      av[i] = 32'hA000_0000 + 32'(i);
      rv[i] = 4'(i + 1);
    end
    dv[3] = 32'hDEAD_BEEF;
    rv[3] = 4'd9;
    for (int i = 0; i < FU; i++) begin
      data_bus[i*W +: W] = dv[i];
      addr_bus[i*W +: W] = av[i];
      rb_bus[i*R +: R] = rv[i];
    end
    tv[0]  = '{1'b0, 1'b0, 8'hFF, 8'h03, 2'b11, 0, 1};
    tv[1]  = '{1'b0, 1'b0, 8'hFF, 8'h0C, 2'b11, 2, 3};
    tv[2]  = '{1'b0, 1'b0, 8'hFF, 8'h30, 2'b11, 4, 5};
    tv[3]  = '{1'b0, 1'b0, 8'hFF, 8'hC0, 2'b11, 6, 7};
    tv[4]  = '{1'b0, 1'b0, 8'h01, 8'h01, 2'b01, 0, 0};
    tv[5]  = '{1'b0, 1'b0, 8'h18, 8'h18, 2'b11, 3, 4};
    tv[6]  = '{1'b0, 1'b0, 8'h81, 8'h81, 2'b11, 7, 0};
    tv[7]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 2'b00, 0, 0};
    tv[8]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 2'b00, 0, 0};
    tv[9]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 2'b00, 0, 0};
    tv[10] = '{1'b0, 1'b0, 8'hFF, 8'h06, 2'b11, 1, 2};
    tv[11] = '{1'b0, 1'b0, 8'h08, 8'h08, 2'b01, 3, 0};
    tv[12] = '{1'b0, 1'b0, 8'h01, 8'h01, 2'b01, 0, 0};
    tv[13] = '{1'b1, 1'b1, 8'hFF, 8'h00, 2'b00, 0, 0};
    tv[14] = '{1'b0, 1'b0, 8'hFF, 8'h03, 2'b11, 0, 1};
    tv[15] = '{1'b0, 1'b0, 8'h44, 8'h44, 2'b11, 2, 6};
    tv[16] = '{1'b0, 1'b0, 8'h7F, 8'h03, 2'b11, 0, 1};
    reset = 1'b1;
    flush = 1'b0;
    hold = 1'b0;
    req = 8'hFF;
    #1;
    chk("reset.gnt", 64'(gnt), 64'h0);
    chk_lanes("reset", 2'b00, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_lanes("reset_clk", 2'b00, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i > 0) @(negedge clk);
      hold = tv[i].hold;
      flush = tv[i].flush;
      req = tv[i].req;
      #1;
      chk($sformatf("v%0d.gnt", i), 64'(gnt), 64'(tv[i].gnt));
      @(posedge clk);
      #1;
      chk_lanes($sformatf("v%0d", i), tv[i].v, tv[i].s0, tv[i].s1);
    end
    // Async reset between edges while lanes are valid; next scan must start at FU0.
    @(negedge clk);
    hold = 1'b0;
    flush = 1'b0;
    req = 8'hFF;
    #1;
    chk("mid.gnt", 64'(gnt), 64'h0C);
    @(posedge clk);
    #1;
    chk_lanes("mid", 2'b11, 2, 3);
    #2;
    reset = 1'b1;
    #1;
    chk("arst.gnt", 64'(gnt), 64'h0);
    chk_lanes("arst", 2'b00, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    req = 8'h81;
    #1;
    chk("post_rst.gnt", 64'(gnt), 64'h81);
    @(posedge clk);
    #1;
    chk_lanes("post_rst", 2'b11, 0, 7);
    gap = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      req = 8'hFF;
      #1;
      gap = gnt[2] ? 0 : gap + 1;
      chk($sformatf("fair%0d.fu2_gap_over_3", c), 64'(gap > 3), 64'h0);
    end
    @(negedge clk);
    req = 8'h00;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
